// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared types and constants for the button conditioner
package btn_conditioner_pkg;

  localparam int N_BTN       = 4;
  localparam int BTN_INC_ANI = 0;
  localparam int BTN_DEC_ANI = 1;
  localparam int BTN_INC_SPD = 2;
  localparam int BTN_DEC_SPD = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } btn_state_e;

  // Inc/dec pairs are adjacent channels, so the partner differs only in bit 0.
  function automatic logic [1:0] partner_of(input logic [1:0] k);
    return k ^ 2'd1;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button conditioner signal bundle
interface btn_conditioner_if;
  import btn_conditioner_pkg::*;

  logic             en_i;
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] pulse_o;

  modport master (output en_i, output btn_i, input level_o, input pulse_o);
  modport slave  (input en_i, input btn_i, output level_o, output pulse_o);

endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one channel: synchroniser, debounce/repeat FSM and counter
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int CNT_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (CNT_AB > REPEAT_PERIOD) ? CNT_AB : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t DLY_LAST = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t PER_LAST = cnt_t'(REPEAT_PERIOD - 1);

  logic [1:0] sync_q;
  logic       sync;
  btn_state_e state, state_nxt;
  cnt_t       cnt, cnt_nxt;

  assign sync = sync_q[1];

  // The synchroniser keeps running while disabled so a held button is seen at once on re-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse     = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state_nxt = IDLE;
          end else if (cnt == DEB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            pulse     = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end else if (REPEAT_EN && cnt == DLY_LAST) begin
            state_nxt = REPEAT;
            cnt_nxt   = '0;
            pulse     = 1'b1;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!sync) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end else if (cnt == PER_LAST) begin
            cnt_nxt = '0;
            pulse   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (sync) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Level follows the next state so the top's output register lines up with the pulse.
  assign level = (state_nxt == HELD) || (state_nxt == REPEAT) || (state_nxt == RELEASE_WAIT);

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - four debounced channels with inc/dec pair-conflict masking
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input logic              clk,
  input logic              rst,
  btn_conditioner_if.slave bus
);

  logic [N_BTN-1:0] lvl_nxt;
  logic [N_BTN-1:0] raw_pulse;
  logic [N_BTN-1:0] pulse_ok;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] pulse_q;

  for (genvar k = 0; k < N_BTN; k++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en_i),
      .btn  (bus.btn_i[k]),
      .level(lvl_nxt[k]),
      .pulse(raw_pulse[k])
    );

    // A command is dropped while its partner is held or fires together with it.
    assign pulse_ok[k] = raw_pulse[k]
                       & ~lvl_nxt[partner_of(2'(k))]
                       & ~raw_pulse[partner_of(2'(k))]
                       & ~pulse_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en_i) begin
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      level_q <= lvl_nxt;
      pulse_q <= pulse_ok;
    end
  end

  assign bus.level_o = level_q;
  assign bus.pulse_o = pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;
  import btn_conditioner_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  btn_conditioner_if ifc_nr ();
  btn_conditioner_if ifc_rp ();

  btn_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
    dut_nr (.clk(clk), .rst(rst), .bus(ifc_nr.slave));
  btn_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8))
    dut (.clk(clk), .rst(rst), .bus(ifc_rp.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if ({ifc_nr.level_o, ifc_nr.pulse_o, ifc_rp.level_o, ifc_rp.pulse_o} !== 16'h0) begin
        miscompares++;
        $display("FAIL reset e=%0d got nr=%b/%b rp=%b/%b want all 0", e,
                 ifc_nr.level_o, ifc_nr.pulse_o, ifc_rp.level_o, ifc_rp.pulse_o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_l, exp_p;
    for (int e = 1; e <= 40; e++) begin
      ifc_nr.btn_i = 4'b0001;
      tick();
      exp_p = (e == 7) ? 4'b0001 : 4'b0000;
      exp_l = (e >= 7) ? 4'b0001 : 4'b0000;
      vectors++;
      if (ifc_nr.pulse_o !== exp_p || ifc_nr.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL clean_press e=%0d got l=%b p=%b want l=%b p=%b", e,
                 ifc_nr.level_o, ifc_nr.pulse_o, exp_l, exp_p);
      end
    end
    for (int e = 1; e <= 12; e++) begin
      ifc_nr.btn_i = 4'b0000;
      tick();
      exp_l = (e >= 7) ? 4'b0000 : 4'b0001;
      vectors++;
      if (ifc_nr.pulse_o !== 4'b0000 || ifc_nr.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL clean_release e=%0d got l=%b p=%b want l=%b p=0000", e,
                 ifc_nr.level_o, ifc_nr.pulse_o, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_l, exp_p;
    logic       raw;
    for (int e = 1; e <= 30; e++) begin
      raw = !(e == 3 || e == 16 || e >= 18);
      ifc_rp.btn_i = {1'b0, raw, 2'b00};
      tick();
      exp_p = (e == 10) ? 4'b0100 : 4'b0000;
      exp_l = (e >= 10 && e < 24) ? 4'b0100 : 4'b0000;
      vectors++;
      if (ifc_rp.pulse_o !== exp_p || ifc_rp.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL bounce e=%0d got l=%b p=%b want l=%b p=%b", e,
                 ifc_rp.level_o, ifc_rp.pulse_o, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] exp_l, exp_p;
    for (int e = 1; e <= 75; e++) begin
      ifc_rp.btn_i = 4'b0000;
      ifc_rp.btn_i[BTN_DEC_ANI] = (e <= 60);
      tick();
      exp_p = (e == 7 || e == 27 || e == 35 || e == 43 || e == 51 || e == 59) ? 4'b0010 : 4'b0000;
      exp_l = (e >= 7 && e < 67) ? 4'b0010 : 4'b0000;
      vectors++;
      if (ifc_rp.pulse_o !== exp_p || ifc_rp.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL auto_repeat e=%0d got l=%b p=%b want l=%b p=%b", e,
                 ifc_rp.level_o, ifc_rp.pulse_o, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_pair_conflict();
    logic [3:0] exp_l, exp_p;
    for (int e = 1; e <= 12; e++) begin
      ifc_rp.btn_i = 4'b0011;
      tick();
      exp_l = (e >= 7) ? 4'b0011 : 4'b0000;
      vectors++;
      if (ifc_rp.pulse_o !== 4'b0000 || ifc_rp.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL pair_same e=%0d got l=%b p=%b want l=%b p=0000", e,
                 ifc_rp.level_o, ifc_rp.pulse_o, exp_l);
      end
    end
    ifc_rp.btn_i = 4'b0000;
    idle(12);
    for (int e = 1; e <= 40; e++) begin
      ifc_rp.btn_i = 4'b0000;
      ifc_rp.btn_i[BTN_INC_SPD] = 1'b1;
      ifc_rp.btn_i[BTN_DEC_SPD] = (e >= 10);
      tick();
      exp_p = (e == 7) ? 4'b0100 : 4'b0000;
      exp_l = {(e >= 16), (e >= 7), 2'b00};
      vectors++;
      if (ifc_rp.pulse_o !== exp_p || ifc_rp.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL pair_held e=%0d got l=%b p=%b want l=%b p=%b", e,
                 ifc_rp.level_o, ifc_rp.pulse_o, exp_l, exp_p);
      end
    end
    ifc_rp.btn_i = 4'b0000;
    idle(12);
    vectors++;
    if (ifc_rp.level_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL pair_release got l=%b want l=0000", ifc_rp.level_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_l, exp_p;
    for (int e = 1; e <= 30; e++) begin
      ifc_rp.btn_i = 4'b0001;
      tick();
      exp_p = (e == 7 || e == 27) ? 4'b0001 : 4'b0000;
      vectors++;
      if (ifc_rp.pulse_o !== exp_p) begin
        miscompares++;
        $display("FAIL reset_mid_pre e=%0d got p=%b want p=%b", e, ifc_rp.pulse_o, exp_p);
      end
    end
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (ifc_rp.pulse_o !== 4'b0000 || ifc_rp.level_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_mid_hold e=%0d got l=%b p=%b want 0000/0000", e,
                 ifc_rp.level_o, ifc_rp.pulse_o);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_p = (e == 7) ? 4'b0001 : 4'b0000;
      exp_l = (e >= 7) ? 4'b0001 : 4'b0000;
      vectors++;
      if (ifc_rp.pulse_o !== exp_p || ifc_rp.level_o !== exp_l) begin
        miscompares++;
        $display("FAIL reset_mid_after e=%0d got l=%b p=%b want l=%b p=%b", e,
                 ifc_rp.level_o, ifc_rp.pulse_o, exp_l, exp_p);
      end
    end
    ifc_rp.btn_i = 4'b0000;
    idle(12);
  endtask

  task automatic test_en_drop();
    int n_pulse;
    for (int e = 1; e <= 10; e++) begin
      ifc_rp.btn_i = 4'b1000;
      tick();
    end
    vectors++;
    if (ifc_rp.level_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL en_pre got l=%b want l=1000", ifc_rp.level_o);
    end
    ifc_rp.en_i = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (ifc_rp.level_o !== 4'b0000 || ifc_rp.pulse_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL en_low e=%0d got l=%b p=%b want 0000/0000", e,
                 ifc_rp.level_o, ifc_rp.pulse_o);
      end
    end
    ifc_rp.en_i = 1'b1;
    n_pulse = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (ifc_rp.pulse_o[BTN_DEC_SPD]) n_pulse++;
      if (e <= 4) begin
        vectors++;
        if (ifc_rp.pulse_o !== 4'b0000) begin
          miscompares++;
          $display("FAIL en_early e=%0d got p=%b want p=0000", e, ifc_rp.pulse_o);
        end
      end
      if (e >= 7) begin
        vectors++;
        if (ifc_rp.level_o !== 4'b1000) begin
          miscompares++;
          $display("FAIL en_level e=%0d got l=%b want l=1000", e, ifc_rp.level_o);
        end
      end
    end
    vectors++;
    if (n_pulse != 1) begin
      miscompares++;
      $display("FAIL en_repress got %0d pulses want 1", n_pulse);
    end
    ifc_rp.btn_i = 4'b0000;
    idle(10);
  endtask

  initial begin
    rst = 1'b1;
    ifc_nr.en_i  = 1'b1;
    ifc_nr.btn_i = 4'b0000;
    ifc_rp.en_i  = 1'b1;
    ifc_rp.btn_i = 4'b0000;
    test_reset();
    idle(2);
    test_clean_press();
    test_bounce();
    idle(4);
    test_auto_repeat();
    idle(4);
    test_pair_conflict();
    test_reset_mid();
    test_en_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
